alu_issue_unit: RTL and testbench
=================================

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; rst asserted forces all state and outputs to reset values immediately, independent of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req_valid_i  input  1  request present.
REQ-005 req_ready_o  output  1  unit can accept a request.
REQ-006 aluop_i  input  2  00 add, 01 sub, 10 decode funct_i, 11 slt.
REQ-007 funct_i  input  6  R-type function code, used only when aluop_i=10.
REQ-008 src1_i / src2_i  input  32 each  operands.
REQ-009 alu_src1_o / alu_src2_o  output  32 each  operands driven to the ALU.
REQ-010 alu_ctrl_o  output  4  ALU control: bit3 A-invert, bit2 B-invert, bits1:0 operation (00 and, 01 or, 10 add, 11 set-less).
REQ-011 alu_rst_o  output  1  ALU enable; ALU outputs are forced to zero while this is 0.
REQ-012 alu_result_i  input  32 / alu_zero_i  input  1  combinational ALU response.
REQ-013 rsp_valid_o  output  1 / rsp_ready_i  input  1  response handshake.
REQ-014 rsp_result_o  output  32 / rsp_zero_o  output  1 / rsp_err_o  output  1  captured response.
REQ-015 op_cnt_o  output  16  count of completed, non-error operations; wraps at 0xFFFF to 0x0000.

Function
REQ-016 Decode SHALL map: add 0010, sub 0110, and 0000, or 0001, nor 1100, slt 0111, sltu 1111; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt, 0x2B sltu.
REQ-017 aluop_i=10 with any other funct SHALL be an illegal request.
REQ-018 FSM states: IDLE, EXEC, RESP.
REQ-019 IDLE: req_ready_o=1; on req_valid_i=1, legal request, register operands and ctrl, go to EXEC; illegal request, go to RESP with err=1, result 0, zero 0, no ALU issue.
REQ-020 EXEC (exactly one cycle): alu_rst_o=1, alu_src*/alu_ctrl_o driven from registers; at the clock edge capture alu_result_i/alu_zero_i into the response register, go to RESP.
REQ-021 RESP: rsp_valid_o=1 with stable outputs until rsp_ready_i=1; on handshake go to IDLE; op_cnt_o increments on the handshake edge when err=0.
REQ-022 req_ready_o SHALL be 0 in EXEC and RESP; requests in those states are not consumed.
REQ-023 Outside EXEC: alu_rst_o=0, alu_src*_o=0, alu_ctrl_o=0000.
REQ-024 Latency: request accepted at edge N gives rsp_valid_o=1 after edge N+2 (legal) or N+1 (illegal); minimum 3 cycles per legal operation.
REQ-025 rsp_ready_i held high before rsp_valid_o rises SHALL complete the handshake in the first RESP cycle.
REQ-026 Response registers SHALL not change while in RESP.

Reset
REQ-027 Reset values: state IDLE, req_ready_o 0 while rst is asserted and 1 in the first cycle after release, rsp_valid_o 0, rsp_result_o 0, rsp_zero_o 0, rsp_err_o 0, op_cnt_o 0, ALU outputs per REQ-023.
REQ-028 Reset during EXEC or RESP SHALL discard the in-flight operation with no response and no count.

Structure
REQ-029 Package alu_issue_pkg SHALL hold the ALU control encodings, funct codes, aluop codes and FSM state type.
REQ-030 Decoding SHALL be one combinational sub-module, alu_ctrl_decode (aluop, funct -> ctrl, illegal).

Verification
REQ-031 Use ALU model. aluop=10, funct 0x20, 5, 7 -> alu_ctrl_o=0010 in EXEC; rsp_result=12, zero=0 at N+2; op_cnt=1 after handshake.
REQ-032 aluop=01, 0x10 and 0x10 -> ctrl 0110, result 0, zero 1.
REQ-033 funct 0x2A, 0xFFFFFFFF and 1 -> result 1; funct 0x2B, same operands -> result 0.
REQ-034 aluop=10, funct 0x3F -> rsp_valid at N+1, err=1, result 0, alu_rst_o stays 0, op_cnt unchanged.
REQ-035 rsp_ready_i=0 for 5 cycles -> rsp outputs stable, req_ready_o=0 throughout; op_cnt preset to 0xFFFF wraps to 0 on completion.
REQ-036 rst pulsed in EXEC -> rsp_valid never rises, op_cnt=0, IDLE after release.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue unit: aluop codes, R-type funct codes,
// ALU control words and the issue FSM state type.
package alu_issue_pkg;

    // aluop field of an issue request
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    // R-type function codes honoured when aluop selects funct decode
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    // ALU control: bit3 A-invert, bit2 B-invert, bits1:0 operation
    // (00 and, 01 or, 10 add, 11 set-less)
    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SLTU = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of request, ALU-side and response signals of the ALU issue unit.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. req: the requester holds req_valid_i and its payload until that
// edge. rsp: rsp_valid_o and the rsp_* payload stay stable until that edge;
// rsp_ready_i may be raised before rsp_valid_o and is not required to wait.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  aluop_i;
    logic [5:0]  funct_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;

    logic [31:0] alu_src1_o;
    logic [31:0] alu_src2_o;
    logic [3:0]  alu_ctrl_o;
    logic        alu_rst_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        rsp_zero_o;
    logic        rsp_err_o;
    logic [15:0] op_cnt_o;

    // FSM state, exposed for debug visibility
    state_t      state_o;

    modport slave (
        input  req_valid_i, aluop_i, funct_i, src1_i, src2_i,
        input  alu_result_i, alu_zero_i, rsp_ready_i,
        output req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o, alu_rst_o,
        output rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_err_o, op_cnt_o,
        output state_o
    );

    modport master (
        output req_valid_i, aluop_i, funct_i, src1_i, src2_i,
        output alu_result_i, alu_zero_i, rsp_ready_i,
        input  req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o, alu_rst_o,
        input  rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_err_o, op_cnt_o,
        input  state_o
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of (aluop, funct) into a 4-bit ALU control word.
// Unknown funct codes under funct decode are flagged illegal.
module alu_ctrl_decode
    import alu_issue_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [3:0] ctrl,
    output logic       illegal
);

    // Map the request opcode to an ALU control word
    always_comb begin
        ctrl    = CTRL_AND;
        illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: ctrl = CTRL_ADD;
            ALUOP_SUB: ctrl = CTRL_SUB;
            ALUOP_SLT: ctrl = CTRL_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD:  ctrl = CTRL_ADD;
                    FUNCT_SUB:  ctrl = CTRL_SUB;
                    FUNCT_AND:  ctrl = CTRL_AND;
                    FUNCT_OR:   ctrl = CTRL_OR;
                    FUNCT_NOR:  ctrl = CTRL_NOR;
                    FUNCT_SLT:  ctrl = CTRL_SLT;
                    FUNCT_SLTU: ctrl = CTRL_SLTU;
                    default:    illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issues one request at a time to an external combinational ALU:
// IDLE accepts and registers the request, EXEC enables the ALU for exactly
// one cycle and captures its result, RESP holds the response until taken.
// Illegal requests skip EXEC and respond with err set.
module alu_issue_unit
    import alu_issue_pkg::*;
#(
    // start value of the completed-operation counter after reset
    parameter logic [15:0] OP_CNT_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    state_t      state_q;
    state_t      state_d;

    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [3:0]  ctrl_q;

    logic [31:0] res_q;
    logic        zero_q;
    logic        err_q;
    logic [15:0] cnt_q;

    logic [3:0]  dec_ctrl;
    logic        dec_illegal;
    logic        req_ready;
    logic        accept;
    logic        in_exec;
    logic        in_resp;
    logic        rsp_fire;

    alu_ctrl_decode u_decode (
        .aluop   (bus.aluop_i),
        .funct   (bus.funct_i),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // ready is held low while rst is asserted even though state reads IDLE
    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_ready && bus.req_valid_i;
    assign in_exec   = (state_q == ST_EXEC);
    assign in_resp   = (state_q == ST_RESP);
    assign rsp_fire  = in_resp && bus.rsp_ready_i;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = dec_illegal ? ST_RESP : ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture operands and decoded control of an accepted legal request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src1_q <= '0;
            src2_q <= '0;
            ctrl_q <= '0;
        end else if (accept && !dec_illegal) begin
            src1_q <= bus.src1_i;
            src2_q <= bus.src2_i;
            ctrl_q <= dec_ctrl;
        end
    end

    // Response register: loaded on illegal accept or at the end of EXEC, frozen in RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept && dec_illegal) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b1;
        end else if (in_exec) begin
            res_q  <= bus.alu_result_i;
            zero_q <= bus.alu_zero_i;
            err_q  <= 1'b0;
        end
    end

    // Count successful operations on their response handshake; wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cnt_q <= OP_CNT_RESET;
        else if (rsp_fire && !err_q) cnt_q <= cnt_q + 16'd1;
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.alu_rst_o    = in_exec;
    assign bus.alu_src1_o   = in_exec ? src1_q : '0;
    assign bus.alu_src2_o   = in_exec ? src2_q : '0;
    assign bus.alu_ctrl_o   = in_exec ? ctrl_q : '0;
    assign bus.rsp_valid_o  = in_resp;
    assign bus.rsp_result_o = res_q;
    assign bus.rsp_zero_o   = zero_q;
    assign bus.rsp_err_o    = err_q;
    assign bus.op_cnt_o     = cnt_q;
    assign bus.state_o      = state_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed vectors, randomized operations against
// an opcode-level reference model, stalls, resets mid-operation and counter wrap.
module tb_alu_issue_unit;
  import alu_issue_pkg::*;

  localparam int W = 38; // {ctrl[3:0], err, zero, result[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if bus ();
  alu_issue_if wbus ();

  alu_issue_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  alu_issue_unit #(.OP_CNT_RESET(16'hFFFF)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus.slave)
  );

  // ---------------- external ALU ----------------
  function automatic logic [32:0] alu_model(input logic en, input logic [3:0] ctrl,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    if (en) begin
      case (ctrl)
        4'b0010: r = a + b;
        4'b0110: r = a - b;
        4'b0000: r = a & b;
        4'b0001: r = a | b;
        4'b1100: r = ~(a | b);
        4'b0111: r = {31'd0, ($signed(a) < $signed(b))};
        4'b1111: r = {31'd0, (a < b)};
        default: r = '0;
      endcase
    end
    return {en && (r == 32'd0), r};
  endfunction

  assign {bus.alu_zero_i, bus.alu_result_i} =
    alu_model(bus.alu_rst_o, bus.alu_ctrl_o, bus.alu_src1_o, bus.alu_src2_o);
  assign {wbus.alu_zero_i, wbus.alu_result_i} =
    alu_model(wbus.alu_rst_o, wbus.alu_ctrl_o, wbus.alu_src1_o, wbus.alu_src2_o);

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_model(input logic [1:0] aluop, input logic [5:0] funct,
                                             input logic [31:0] a, input logic [31:0] b);
    int          kind;
    logic [31:0] r;
    logic [3:0]  c;
    kind = -1;
    if (aluop == 2'b00)      kind = 0;
    else if (aluop == 2'b01) kind = 1;
    else if (aluop == 2'b11) kind = 5;
    else begin
      case (funct)
        6'h20:   kind = 0;
        6'h22:   kind = 1;
        6'h24:   kind = 2;
        6'h25:   kind = 3;
        6'h27:   kind = 4;
        6'h2A:   kind = 5;
        6'h2B:   kind = 6;
        default: kind = -1;
      endcase
    end
    r = '0;
    c = '0;
    case (kind)
      0: begin r = a + b;    c = 4'b0010; end
      1: begin r = a - b;    c = 4'b0110; end
      2: begin r = a & b;    c = 4'b0000; end
      3: begin r = a | b;    c = 4'b0001; end
      4: begin r = ~(a | b); c = 4'b1100; end
      5: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; c = 4'b0111; end
      6: begin r = (a < b) ? 32'd1 : 32'd0; c = 4'b1111; end
      default: ;
    endcase
    if (kind < 0) return {4'b0000, 1'b1, 1'b0, 32'd0};
    return {c, 1'b0, (r == 32'd0), r};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_cnt;
  logic [31:0]  last_res;
  logic         last_zero;
  logic         last_err;
  int           n_vec = 0;
  int           n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_op(input logic [1:0] aluop, input logic [5:0] funct,
                       input logic [31:0] a, input logic [31:0] b,
                       input int stall, input bit early);
    logic [W-1:0] e;
    e = ref_model(aluop, funct, a, b);
    exp_q.push_back(e);
    @(posedge clk); #1;
    check("idle_ready", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1;
    bus.aluop_i     = aluop;
    bus.funct_i     = funct;
    bus.src1_i      = a;
    bus.src2_i      = b;
    bus.rsp_ready_i = early;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    check("busy_ready", 32'(bus.req_ready_o), 32'd0);
    if (!e[33]) begin
      check("exec_state", 32'(bus.state_o), 32'(ST_EXEC));
      check("exec_alu_en", 32'(bus.alu_rst_o), 32'd1);
      check("exec_ctrl", 32'(bus.alu_ctrl_o), 32'(e[37:34]));
      check("exec_src1", bus.alu_src1_o, a);
      check("exec_src2", bus.alu_src2_o, b);
      check("exec_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      @(posedge clk); #1;
    end else begin
      check("err_alu_en", 32'(bus.alu_rst_o), 32'd0);
    end
    check("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    check("resp_alu_en", 32'(bus.alu_rst_o), 32'd0);
    check("resp_alu_ctrl", 32'(bus.alu_ctrl_o), 32'd0);
    check("resp_alu_src", bus.alu_src1_o | bus.alu_src2_o, 32'd0);
    e = exp_q.pop_front();
    check("rsp_result", bus.rsp_result_o, e[31:0]);
    check("rsp_zero", 32'(bus.rsp_zero_o), 32'(e[32]));
    check("rsp_err", 32'(bus.rsp_err_o), 32'(e[33]));
    last_res  = bus.rsp_result_o;
    last_zero = bus.rsp_zero_o;
    last_err  = bus.rsp_err_o;
    if (!early) begin
      for (int k = 0; k < stall; k++) begin
        bus.req_valid_i = 1'b1;
        bus.aluop_i     = 2'($urandom_range(0, 3));
        bus.src1_i      = $urandom;
        @(posedge clk); #1;
        check("stall_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("stall_ready", 32'(bus.req_ready_o), 32'd0);
        check("stall_result", bus.rsp_result_o, e[31:0]);
        check("stall_zero", 32'(bus.rsp_zero_o), 32'(e[32]));
        check("stall_err", 32'(bus.rsp_err_o), 32'(e[33]));
        check("stall_cnt", 32'(bus.op_cnt_o), 32'(exp_cnt));
      end
      bus.req_valid_i = 1'b0;
      bus.rsp_ready_i = 1'b1;
    end
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    if (!e[33]) exp_cnt++;
    check("post_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("post_state", 32'(bus.state_o), 32'(ST_IDLE));
    check("op_cnt", 32'(bus.op_cnt_o), 32'(exp_cnt));
  endtask

  // Pulse rst while an add is in EXEC (where=1) or RESP (where=2)
  task automatic reset_mid(input int where);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1;
    bus.aluop_i     = 2'b00;
    bus.src1_i      = 32'd9;
    bus.src2_i      = 32'd9;
    bus.rsp_ready_i = 1'b0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    if (where == 2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_async_alu", 32'(bus.alu_rst_o), 32'd0);
    check("rst_async_ready", 32'(bus.req_ready_o), 32'd0);
    check("rst_async_cnt", 32'(bus.op_cnt_o), 32'd0);
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'd0;
    exp_q.delete();
    #1;
    check("rst_rel_state", 32'(bus.state_o), 32'(ST_IDLE));
    check("rst_rel_ready", 32'(bus.req_ready_o), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("rst_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
      check("rst_cnt", 32'(bus.op_cnt_o), 32'd0);
    end
    bus.rsp_ready_i = 1'b0;
  endtask

  // Counter starting at 0xFFFF wraps to 0 on a stalled, then completed, add
  task automatic wrap_test;
    @(posedge clk); #1;
    check("wrap_preset", 32'(wbus.op_cnt_o), 32'h0000FFFF);
    wbus.req_valid_i = 1'b1;
    wbus.aluop_i     = 2'b00;
    wbus.src1_i      = 32'd3;
    wbus.src2_i      = 32'd4;
    @(posedge clk); #1;
    wbus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    check("wrap_valid", 32'(wbus.rsp_valid_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("wrap_stall_valid", 32'(wbus.rsp_valid_o), 32'd1);
      check("wrap_stall_ready", 32'(wbus.req_ready_o), 32'd0);
      check("wrap_stall_res", wbus.rsp_result_o, 32'd7);
      check("wrap_stall_zero", 32'(wbus.rsp_zero_o), 32'd0);
      check("wrap_stall_cnt", 32'(wbus.op_cnt_o), 32'h0000FFFF);
    end
    wbus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    wbus.rsp_ready_i = 1'b0;
    check("wrap_done_valid", 32'(wbus.rsp_valid_o), 32'd0);
    check("wrap_cnt", 32'(wbus.op_cnt_o), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.req_valid_i  = 1'b0;
    bus.aluop_i      = 2'b00;
    bus.funct_i      = 6'h00;
    bus.src1_i       = '0;
    bus.src2_i       = '0;
    bus.rsp_ready_i  = 1'b0;
    wbus.req_valid_i = 1'b0;
    wbus.aluop_i     = 2'b00;
    wbus.funct_i     = 6'h00;
    wbus.src1_i      = '0;
    wbus.src2_i      = '0;
    wbus.rsp_ready_i = 1'b0;
    exp_cnt          = 16'd0;
    last_res         = '0;
    last_zero        = 1'b0;
    last_err         = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready_o), 32'd0);
    check("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_result", bus.rsp_result_o, 32'd0);
    check("rst_zero", 32'(bus.rsp_zero_o), 32'd0);
    check("rst_err", 32'(bus.rsp_err_o), 32'd0);
    check("rst_cnt", 32'(bus.op_cnt_o), 32'd0);
    check("rst_alu_en", 32'(bus.alu_rst_o), 32'd0);
    check("rst_alu_ctrl", 32'(bus.alu_ctrl_o), 32'd0);
    check("rst_alu_src", bus.alu_src1_o | bus.alu_src2_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready", 32'(bus.req_ready_o), 32'd1);
    check("rel_state", 32'(bus.state_o), 32'(ST_IDLE));

    // directed vectors
    do_op(2'b10, 6'h20, 32'd5, 32'd7, 0, 1'b0);
    check("add_result", last_res, 32'd12);
    check("add_zero", 32'(last_zero), 32'd0);
    check("add_cnt", 32'(bus.op_cnt_o), 32'd1);
    do_op(2'b01, 6'h00, 32'h10, 32'h10, 1, 1'b0);
    check("sub_result", last_res, 32'd0);
    check("sub_zero", 32'(last_zero), 32'd1);
    do_op(2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1, 0, 1'b1);
    check("slt_result", last_res, 32'd1);
    do_op(2'b10, 6'h2B, 32'hFFFFFFFF, 32'd1, 0, 1'b1);
    check("sltu_result", last_res, 32'd0);
    do_op(2'b10, 6'h3F, 32'd1, 32'd2, 2, 1'b0);
    check("ill_err", 32'(last_err), 32'd1);
    check("ill_result", last_res, 32'd0);
    check("ill_cnt", 32'(bus.op_cnt_o), 32'd4);
    do_op(2'b00, 6'h00, 32'h1234, 32'h4321, 5, 1'b0);

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 8);
      case (sel)
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h25;
        4: fn = 6'h27;
        5: fn = 6'h2A;
        6: fn = 6'h2B;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        a = 32'($urandom_range(0, 8));
        b = 32'($urandom_range(0, 8));
      end
      do_op(op, fn, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // reset mid-operation, then normal operation resumes from a zero count
    reset_mid(1);
    reset_mid(2);
    do_op(2'b11, 6'h00, 32'd3, 32'd8, 0, 1'b0);
    check("after_rst_cnt", 32'(bus.op_cnt_o), 32'd1);

    wrap_test();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
